// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: per-channel PLL reset sequencing, lock synchronisation and qualification,
// sticky lock-loss detection and bounded auto-retry ending in a latched fault.
module pll_lock_supervisor #(
    parameter int CHANNELS      = 2,
    parameter int SYNC_STAGES   = 3,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] lock_in,
    input  logic [CHANNELS-1:0] clr_fault,
    output logic [CHANNELS-1:0] pll_rst,
    output logic [CHANNELS-1:0] lock_ok,
    output logic [CHANNELS-1:0] lock_lost,
    output logic [CHANNELS-1:0] fail,
    output logic                all_locked,
    output logic                fail_any
);
    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_END  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {S_RST, S_WAIT, S_QUAL, S_LOCKED, S_FAIL} state_t;

    assign all_locked = &lock_ok;
    assign fail_any   = |fail;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state, w_next;
        logic [CW-1:0]          r_cnt, w_cnt;
        logic [RW-1:0]          r_rty, w_rty;
        logic                   r_pll_rst, r_lock_ok, r_lost, r_fail;
        logic                   w_lock_s, w_att_fail;

        assign w_lock_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync    <= '0;
                r_state   <= S_RST;
                r_cnt     <= '0;
                r_rty     <= '0;
                r_pll_rst <= 1'b1;
                r_lock_ok <= 1'b0;
                r_lost    <= 1'b0;
                r_fail    <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], lock_in[g]};
                r_state   <= w_next;
                r_cnt     <= w_cnt;
                r_rty     <= w_rty;
                // Outputs are registered from the next state so they track the FSM without lag
                r_pll_rst <= (w_next == S_RST) || (w_next == S_FAIL);
                r_lock_ok <= (w_next == S_LOCKED);
                r_fail    <= (w_next == S_FAIL);
                // A loss in the same cycle as a clear keeps the flag set
                r_lost    <= ((r_state == S_LOCKED) && !w_lock_s) || (r_lost && !clr_fault[g]);
            end
        end

        always_comb begin
            w_next     = r_state;
            w_cnt      = r_cnt;
            w_rty      = r_rty;
            w_att_fail = 1'b0;
            case (r_state)
                S_RST: begin
                    w_next = (r_cnt == RST_END) ? S_WAIT : S_RST;
                    w_cnt  = (r_cnt == RST_END) ? '0 : r_cnt + CW'(1);
                end
                S_WAIT: begin
                    if (w_lock_s) begin
                        w_next = S_QUAL;
                        w_cnt  = '0;
                    end else if (r_cnt == TO_END) begin
                        w_att_fail = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                S_QUAL: begin
                    if (!w_lock_s) begin
                        w_att_fail = 1'b1;
                    end else if (r_cnt == ST_END) begin
                        w_next = S_LOCKED;
                        w_rty  = '0;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                S_LOCKED: begin
                    w_next = w_lock_s ? S_LOCKED : S_RST;
                    w_cnt  = w_lock_s ? r_cnt : '0;
                end
                S_FAIL: begin
                    w_next = clr_fault[g] ? S_RST : S_FAIL;
                    w_cnt  = clr_fault[g] ? '0 : r_cnt;
                    w_rty  = clr_fault[g] ? '0 : r_rty;
                end
                default: begin
                    w_next = S_RST;
                    w_cnt  = '0;
                end
            endcase
            if (w_att_fail) begin
                w_next = (r_rty == RTY_MAX) ? S_FAIL : S_RST;
                w_rty  = (r_rty == RTY_MAX) ? r_rty : r_rty + RW'(1);
                w_cnt  = '0;
            end
        end

        assign pll_rst[g]   = r_pll_rst;
        assign lock_ok[g]   = r_lock_ok;
        assign lock_lost[g] = r_lost;
        assign fail[g]      = r_fail;
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench; each output change per channel (and of the
// global summary pair) is matched against a queue of hand-timed expected events.
module tb_pll_lock_supervisor;
    logic       clk;
    logic       rst_n;
    logic [1:0] lock_in;
    logic [1:0] clr_fault;
    logic [1:0] pll_rst;
    logic [1:0] lock_ok;
    logic [1:0] lock_lost;
    logic [1:0] fail;
    logic       all_locked;
    logic       fail_any;

    pll_lock_supervisor #(
        .CHANNELS(2), .SYNC_STAGES(3), .RST_CYCLES(16),
        .LOCK_TIMEOUT(64), .STABLE_CYCLES(32), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .clr_fault(clr_fault),
        .pll_rst(pll_rst), .lock_ok(lock_ok), .lock_lost(lock_lost), .fail(fail),
        .all_locked(all_locked), .fail_any(fail_any)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  v;
    } ev_t;

    ev_t        q [3][$];
    logic [3:0] prev [3];
    logic [3:0] cur [3];
    logic       first = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Streams: 0/1 = channel {fail, lock_lost, lock_ok, pll_rst}; 2 = {all_locked, fail_any}
    always @(negedge clk) begin
        ev_t e;
        cur[0] = {fail[0], lock_lost[0], lock_ok[0], pll_rst[0]};
        cur[1] = {fail[1], lock_lost[1], lock_ok[1], pll_rst[1]};
        cur[2] = {2'b00, all_locked, fail_any};
        for (int s = 0; s < 3; s++) begin
            if (first || cur[s] !== prev[s]) begin
                checks++;
                if (q[s].size() == 0) begin
                    errors++;
                    $display("FAIL stream%0d unexpected change: cycle %0d got %b, expected no event", s, cyc, cur[s]);
                end else begin
                    e = q[s].pop_front();
                    if (e.cyc != 32'(cyc) || e.v !== cur[s]) begin
                        errors++;
                        $display("FAIL stream%0d event: got cycle %0d value %b, expected cycle %0d value %b",
                                 s, cyc, cur[s], e.cyc, e.v);
                    end
                end
                prev[s] = cur[s];
            end
        end
        first = 1'b0;
    end

    task automatic expect_ev(input int s, input int c, input logic [3:0] v);
        ev_t e;
        e.cyc = 32'(c);
        e.v   = v;
        q[s].push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        lock_in   = 2'b00;
        clr_fault = 2'b00;
        // Reset values, reset release, and channel 1 timing out three times into FAIL
        expect_ev(0, 1, 4'b0001);   expect_ev(0, 21, 4'b0000);
        expect_ev(1, 1, 4'b0001);   expect_ev(1, 21, 4'b0000);
        expect_ev(1, 85, 4'b0001);  expect_ev(1, 101, 4'b0000);
        expect_ev(1, 165, 4'b0001); expect_ev(1, 181, 4'b0000);
        expect_ev(1, 245, 4'b1001);
        expect_ev(2, 1, 4'b0000);   expect_ev(2, 245, 4'b0001);
        wait_cyc(5);   rst_n = 1'b1;
        // Clean lock on channel 0: lock_ok 36 cycles after lock_in rises
        wait_cyc(31);  lock_in[0] = 1'b1;
        expect_ev(0, 67, 4'b0010);
        // Loss while locked, then relock with the sticky flag held
        wait_cyc(100); lock_in[0] = 1'b0;
        expect_ev(0, 104, 4'b0101); expect_ev(0, 120, 4'b0100); expect_ev(0, 153, 4'b0110);
        wait_cyc(104); lock_in[0] = 1'b1;
        // Clear channel 1 out of FAIL
        wait_cyc(260); clr_fault[1] = 1'b1;
        expect_ev(1, 261, 4'b0001); expect_ev(1, 277, 4'b0000);
        expect_ev(2, 261, 4'b0000);
        wait_cyc(261); clr_fault[1] = 1'b0;
        // Qualification drop near qual cycle 20, then a stable lock
        wait_cyc(280); lock_in[1] = 1'b1;
        wait_cyc(303); lock_in[1] = 1'b0;
        expect_ev(1, 307, 4'b0001); expect_ev(1, 323, 4'b0000); expect_ev(1, 356, 4'b0010);
        expect_ev(2, 356, 4'b0010);
        wait_cyc(306); lock_in[1] = 1'b1;
        // Clear the sticky flag on channel 0
        wait_cyc(370); clr_fault[0] = 1'b1;
        expect_ev(0, 371, 4'b0010);
        wait_cyc(371); clr_fault[0] = 1'b0;
        // Clear coincident with a fresh loss: the set must win
        wait_cyc(400); lock_in[0] = 1'b0;
        expect_ev(0, 404, 4'b0101); expect_ev(0, 420, 4'b0100); expect_ev(0, 453, 4'b0110);
        expect_ev(2, 404, 4'b0000); expect_ev(2, 453, 4'b0010);
        wait_cyc(403); clr_fault[0] = 1'b1;
        wait_cyc(404); clr_fault[0] = 1'b0; lock_in[0] = 1'b1;
        // Loss on channel 1 with lock gone: a full three attempts proves retries were cleared
        wait_cyc(470); lock_in[1] = 1'b0;
        expect_ev(1, 474, 4'b0101); expect_ev(1, 490, 4'b0100);
        expect_ev(1, 554, 4'b0101); expect_ev(1, 570, 4'b0100);
        expect_ev(1, 634, 4'b0101); expect_ev(1, 650, 4'b0100);
        expect_ev(1, 714, 4'b1101);
        expect_ev(2, 474, 4'b0000); expect_ev(2, 714, 4'b0001);
        // Clear FAIL (also clears lock_lost), enter QUAL, then reset mid-qualification
        wait_cyc(730); clr_fault[1] = 1'b1;
        expect_ev(1, 731, 4'b0001); expect_ev(1, 747, 4'b0000);
        expect_ev(2, 731, 4'b0000);
        wait_cyc(731); clr_fault[1] = 1'b0;
        wait_cyc(750); lock_in[1] = 1'b1;
        wait_cyc(760); rst_n = 1'b0;
        expect_ev(0, 761, 4'b0001); expect_ev(0, 781, 4'b0000); expect_ev(0, 814, 4'b0010);
        expect_ev(1, 761, 4'b0001); expect_ev(1, 781, 4'b0000); expect_ev(1, 814, 4'b0010);
        expect_ev(2, 814, 4'b0010);
        wait_cyc(765); rst_n = 1'b1;
        wait_cyc(840);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (q[s].size() != 0) begin
                errors++;
                $display("FAIL stream%0d pending: %0d expected events never seen, next at cycle %0d",
                         s, q[s].size(), q[s][0].cyc);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Synthesisable multi-channel PLL lock supervisor. It replaces the bench-only lock-checking logic used alongside our PLL IP. Per channel it:
- sequences the PLL reset;
- synchronises the asynchronous `lock` output;
- qualifies a stable lock;
- detects lock loss with a sticky flag;
- auto-retries a bounded number of times before declaring a fault.

It sits in the system clock domain between the PLL instances and the design's reset and status logic.

## Interface
- `CHANNELS`, 2: number of supervised PLLs (1–8).
- `SYNC_STAGES`, 3: flops in each lock synchroniser (≥2).
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 4096: cycles to wait for lock after releasing `pll_rst` (≥2).
- `STABLE_CYCLES`, 256: consecutive synchronised-lock-high cycles needed to qualify (≥1).
- `MAX_RETRY`, 3: failed attempts allowed before FAIL; total attempts = `MAX_RETRY`+1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `lock_in`  in  CHANNELS  raw PLL lock outputs; asynchronous to `clk`.
- `clr_fault`  in  CHANNELS  one-cycle pulse per channel; clears the sticky flag and FAIL.
- `pll_rst`  out  CHANNELS  active-high reset to each PLL; registered.
- `lock_ok`  out  CHANNELS  channel is in LOCKED; registered.
- `lock_lost`  out  CHANNELS  sticky flag: lock dropped while LOCKED.
- `fail`  out  CHANNELS  channel exhausted its retries.
- `all_locked`  out  1  AND of all `lock_ok` bits.
- `fail_any`  out  1  OR of all `fail` bits.

## Operation
Each channel has an independent FSM, one shared-width counter `cnt` and a retry counter `rty`.
- Counter widths are `$clog2` of (max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`)+1) and (`MAX_RETRY`+1) respectively.
- `lock_s` is the output of the last synchroniser stage.

FSM states and transitions:
- **RST**: `pll_rst`=1. `cnt` counts 0..`RST_CYCLES`-1. At `RST_CYCLES`-1 go to WAIT, `cnt`←0.
- **WAIT**: `pll_rst`=0.
  - `lock_s`=1 → QUAL, `cnt`←0.
  - Otherwise, if `cnt`==`LOCK_TIMEOUT`-1, the attempt has failed.
  - Otherwise `cnt`++.
- **QUAL**: `pll_rst`=0.
  - `lock_s`=0 → attempt failed.
  - `cnt`==`STABLE_CYCLES`-1 → LOCKED.
  - Otherwise `cnt`++.
- **LOCKED**: `lock_ok`=1. Entering LOCKED sets `rty`←0. `lock_s`=0 → set `lock_lost`, go to RST, `cnt`←0. A loss from LOCKED does not count as a failed attempt.
- **FAIL**: `pll_rst`=1, `fail`=1. Leave only on `clr_fault` → RST with `rty`←0, `cnt`←0, `fail`←0.

Failed attempt:
- If `rty`==`MAX_RETRY`, go to FAIL.
- Otherwise `rty`++ and go to RST, `cnt`←0.

`clr_fault` behaviour:
- In any state, `clr_fault` clears `lock_lost`.
- If `lock_lost` would be set in the same cycle, set wins.
- In states other than FAIL, `clr_fault` has no other effect.

## Timing
- **Reset** (`rst_n`=0 on a clock edge): for every channel, state=RST, `cnt`=0, `rty`=0, synchronisers=0, `pll_rst`=1, `lock_ok`=0, `lock_lost`=0, `fail`=0. Hence `all_locked`=0 and `fail_any`=0.
- **Reset mid-operation**: asserting `rst_n` from any state, including FAIL, aborts immediately with the values above.
- **Reset release**: `pll_rst` stays high for exactly `RST_CYCLES` edges after the first edge with `rst_n`=1, then falls.
- **Sync latency**: a change on `lock_in` appears on `lock_s` after `SYNC_STAGES` edges, plus up to one cycle of sampling uncertainty.
- **Lock qualification**: if `lock_s` first reads 1 at edge t (state WAIT), `lock_ok` rises at edge t+`STABLE_CYCLES`+1.
- **Lock-loss response**: if `lock_s` reads 0 at edge t (state LOCKED), then at t+1 `lock_ok`=0, `lock_lost`=1 and `pll_rst`=1.
- **Timeout**: a WAIT with `lock_s` held 0 lasts exactly `LOCK_TIMEOUT` cycles before `pll_rst` re-asserts.
- **`lock_in` glitches**: glitches shorter than one clock may be missed. That is acceptable, since qualification requires `STABLE_CYCLES` of continuous high.
- **Channel independence**: no shared state between channels. Simultaneous events on different channels are handled independently in the same cycle.

## Test plan
Bench parameters: `CHANNELS`=2, `SYNC_STAGES`=3, `RST_CYCLES`=16, `LOCK_TIMEOUT`=64, `STABLE_CYCLES`=32, `MAX_RETRY`=2.

1. **Reset values**: hold `rst_n`=0 for 5 cycles → all outputs at reset values. Release → `pll_rst`[0] is 1 for exactly 16 cycles.
2. **Clean lock**: model the PLL as `lock_in`=1 ten cycles after `pll_rst` falls → `lock_ok` rises 3+32+1 (±1) cycles after the `lock_in` edge. `all_locked`=1 once both channels lock, `rty`=0.
3. **Timeout and FAIL**: hold `lock_in`[1]=0 → three attempts, each 16 cycles of `pll_rst` followed by 64 cycles of wait. Then `fail`[1]=1, `fail_any`=1, `pll_rst`[1] held at 1, while channel 0 is unaffected.
4. **Qualification drop**: drop `lock_in` for 3 cycles at qualification cycle 20 → counted as a retry, back to RST. A later stable lock → LOCKED with `rty` cleared.
5. **Loss while locked**: drop `lock_in`[0] for 4 cycles while LOCKED → next edge after `lock_s`=0: `lock_ok`=0, `lock_lost`[0]=1, RST sequence restarts. `lock_lost` stays 1 after relock until `clr_fault`[0].
6. **Clear and simultaneous events**: `clr_fault`[1] pulse in FAIL → RST, `fail`=0. `clr_fault` coincident with a lock loss → `lock_lost`=1. `rst_n`=0 during QUAL → reset values on the next edge.
